// File: rtl/lms_pkg.sv
// Shared types and sizing helpers for the LMS convergence monitor.
package lms_pkg;

  typedef enum logic [1:0] {
    ACQUIRE   = 2'd0,
    LOCKING   = 2'd1,
    CONVERGED = 2'd2
  } lms_state_e;

  localparam int W1_DEF = 8;
  localparam int W2_DEF = 16;

  // Squares are 2*W2 wide; a 2^log2_win sample window needs log2_win growth bits.
  function automatic int acc_width(input int w2, input int log2_win);
    return 2 * w2 + log2_win;
  endfunction

endpackage

// File: rtl/lms_conv_monitor_if.sv
// Error/coefficient stream in, MSE and lock status out, for the LMS convergence monitor.
interface lms_conv_monitor_if #(
  parameter int W1 = 8,
  parameter int W2 = 16
);
  logic signed [W2-1:0]   e_in;
  logic                   e_valid;
  logic [W1-1:0]          f0_in;
  logic [W1-1:0]          f1_in;
  logic [2*W2-1:0]        thresh_lo;
  logic [2*W2-1:0]        thresh_hi;
  logic [2*W2-1:0]        mse_out;
  logic                   mse_valid;
  logic                   converged;
  logic                   lost;
  logic [W1-1:0]          f0_snap;
  logic [W1-1:0]          f1_snap;

  modport master (
    output e_in, e_valid, f0_in, f1_in, thresh_lo, thresh_hi,
    input  mse_out, mse_valid, converged, lost, f0_snap, f1_snap
  );

  modport slave (
    input  e_in, e_valid, f0_in, f1_in, thresh_lo, thresh_hi,
    output mse_out, mse_valid, converged, lost, f0_snap, f1_snap
  );
endinterface

// File: rtl/lms_mse_window.sv
// Two-stage windowed mean-squared error: square, then accumulate 2^LOG2_WIN valid samples.
module lms_mse_window
  import lms_pkg::*;
#(
  parameter int W2       = W2_DEF,
  parameter int LOG2_WIN = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic signed [W2-1:0] e_in,
  input  logic                 e_valid,
  output logic [2*W2-1:0]      mse_out,
  output logic                 mse_valid
);

  localparam int ACC_W = acc_width(W2, LOG2_WIN);

  logic signed [2*W2-1:0] prod;
  logic [2*W2-1:0]        sq;
  logic                   sq_v;
  logic [ACC_W-1:0]       acc;
  logic [ACC_W-1:0]       sum;
  logic [LOG2_WIN-1:0]    cnt;

  // Full-width signed product: (-2^(W2-1))^2 = 2^(2*W2-2) still fits unsigned.
  assign prod = e_in * e_in;
  assign sum  = acc + ACC_W'(sq);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sq        <= '0;
      sq_v      <= 1'b0;
      acc       <= '0;
      cnt       <= '0;
      mse_out   <= '0;
      mse_valid <= 1'b0;
    end else begin
      mse_valid <= 1'b0;
      if (clear) begin
        sq_v <= 1'b0;
        acc  <= '0;
        cnt  <= '0;
      end else begin
        sq_v <= e_valid;
        if (e_valid) begin
          sq <= prod;
        end
        if (sq_v) begin
          if (cnt == '1) begin
            mse_out   <= sum[ACC_W-1:LOG2_WIN];
            mse_valid <= 1'b1;
            acc       <= '0;
            cnt       <= '0;
          end else begin
            acc <= sum;
            cnt <= cnt + LOG2_WIN'(1);
          end
        end
      end
    end
  end

endmodule

// File: rtl/lms_conv_monitor.sv
// LMS convergence monitor: windowed MSE, lock/loss hysteresis FSM, coefficient snapshot at lock.
//   state     | meaning
//   ACQUIRE   | no good windows yet, waiting for MSE < thresh_lo
//   LOCKING   | counting consecutive good windows toward LOCK_CNT
//   CONVERGED | locked; only MSE > thresh_hi drops back to ACQUIRE
module lms_conv_monitor
  import lms_pkg::*;
#(
  parameter int W1       = W1_DEF,
  parameter int W2       = W2_DEF,
  parameter int LOG2_WIN = 5,
  parameter int LOCK_CNT = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  lms_conv_monitor_if.slave  bus
);

  localparam int LCW = $clog2(LOCK_CNT + 1);

  lms_state_e       state;
  logic [LCW-1:0]   lock_cnt;
  logic [2*W2-1:0]  mse;
  logic             mse_v;
  logic             converged;
  logic             lost;
  logic [W1-1:0]    f0_snap;
  logic [W1-1:0]    f1_snap;

  lms_mse_window #(
    .W2       (W2),
    .LOG2_WIN (LOG2_WIN)
  ) u_mse (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .e_in      (bus.e_in),
    .e_valid   (bus.e_valid),
    .mse_out   (mse),
    .mse_valid (mse_v)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ACQUIRE;
      lock_cnt  <= '0;
      converged <= 1'b0;
      lost      <= 1'b0;
      f0_snap   <= '0;
      f1_snap   <= '0;
    end else begin
      lost <= 1'b0;
      if (clear) begin
        state     <= ACQUIRE;
        lock_cnt  <= '0;
        converged <= 1'b0;
      end else if (mse_v) begin
        case (state)
          ACQUIRE: begin
            if (mse < bus.thresh_lo) begin
              lock_cnt <= LCW'(1);
              if (LOCK_CNT == 1) begin
                state     <= CONVERGED;
                converged <= 1'b1;
                f0_snap   <= bus.f0_in;
                f1_snap   <= bus.f1_in;
              end else begin
                state <= LOCKING;
              end
            end
          end
          LOCKING: begin
            if (mse < bus.thresh_lo) begin
              lock_cnt <= lock_cnt + LCW'(1);
              if (lock_cnt + LCW'(1) == LCW'(LOCK_CNT)) begin
                state     <= CONVERGED;
                converged <= 1'b1;
                f0_snap   <= bus.f0_in;
                f1_snap   <= bus.f1_in;
              end
            end else begin
              state    <= ACQUIRE;
              lock_cnt <= '0;
            end
          end
          CONVERGED: begin
            // Values between the thresholds hold lock.
            if (mse > bus.thresh_hi) begin
              state     <= ACQUIRE;
              lock_cnt  <= '0;
              converged <= 1'b0;
              lost      <= 1'b1;
            end
          end
          default: begin
            state    <= ACQUIRE;
            lock_cnt <= '0;
          end
        endcase
      end
    end
  end

  assign bus.mse_out   = mse;
  assign bus.mse_valid = mse_v;
  assign bus.converged = converged;
  assign bus.lost      = lost;
  assign bus.f0_snap   = f0_snap;
  assign bus.f1_snap   = f1_snap;

endmodule

// File: tb/tb_lms_conv_monitor.sv
// Directed bench for lms_conv_monitor: MSE windows, lock/loss hysteresis, clear and reset restart.
module tb_lms_conv_monitor;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clear = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   mv_cnt = 0;
  int   lost_cnt = 0;
  logic [31:0] last_mse = '0;

  lms_conv_monitor_if #(.W1(8), .W2(16)) bus ();

  lms_conv_monitor #(
    .W1(8), .W2(16), .LOG2_WIN(5), .LOCK_CNT(4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.mse_valid === 1'b1) begin
      mv_cnt++;
      last_mse = bus.mse_out;
    end
    if (bus.lost === 1'b1) lost_cnt++;
  end

  task automatic send_sample(input int e, input logic v);
    bus.e_in = 16'(e);
    bus.e_valid = v;
    @(posedge clk);
    #1;
  endtask

  // 32 valid samples alternating a/b; optional invalid cycles carry junk data.
  task automatic send_window(input int a, input int b, input bit gaps);
    for (int i = 0; i < 32; i++) begin
      if (gaps && $urandom_range(0, 2) == 0) send_sample(32767, 1'b0);
      send_sample((i % 2 == 0) ? a : b, 1'b1);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear = 1'b0;
    bus.e_in = '0;
    bus.e_valid = 1'b0;
    bus.f0_in = '0;
    bus.f1_in = '0;
    bus.thresh_lo = '0;
    bus.thresh_hi = '1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({bus.mse_out, bus.mse_valid, bus.converged, bus.lost, bus.f0_snap, bus.f1_snap} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got mse=%0d mv=%0b conv=%0b lost=%0b f0=%h f1=%h exp all 0",
               bus.mse_out, bus.mse_valid, bus.converged, bus.lost, bus.f0_snap, bus.f1_snap);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_basic_window();
    send_window(16, 16, 1'b0);
    checks++;
    if (bus.mse_valid !== 1'b0) begin
      errors++;
      $display("FAIL t1_mv_early got %0b exp 0", bus.mse_valid);
    end
    send_sample(0, 1'b0);
    checks++;
    if (bus.mse_valid !== 1'b1 || bus.mse_out !== 32'd256) begin
      errors++;
      $display("FAIL t1_mse got mv=%0b mse=%0d exp mv=1 mse=256", bus.mse_valid, bus.mse_out);
    end
    send_sample(0, 1'b0);
    checks++;
    if (bus.mse_valid !== 1'b0 || bus.converged !== 1'b0) begin
      errors++;
      $display("FAIL t1_after got mv=%0b conv=%0b exp mv=0 conv=0", bus.mse_valid, bus.converged);
    end
  endtask

  task automatic test_corner_and_gaps();
    int mv0;
    send_window(-32768, -32768, 1'b0);
    send_sample(0, 1'b0);
    checks++;
    if (bus.mse_valid !== 1'b1 || bus.mse_out !== 32'h4000_0000) begin
      errors++;
      $display("FAIL t2_min_square got mv=%0b mse=%h exp mv=1 mse=40000000", bus.mse_valid, bus.mse_out);
    end
    send_sample(0, 1'b0);
    mv0 = mv_cnt;
    send_window(3, -3, 1'b1);
    send_sample(0, 1'b0);
    checks++;
    if (bus.mse_valid !== 1'b1 || bus.mse_out !== 32'd9) begin
      errors++;
      $display("FAIL t2_gaps got mv=%0b mse=%0d exp mv=1 mse=9", bus.mse_valid, bus.mse_out);
    end
    send_sample(0, 1'b0);
    checks++;
    if (mv_cnt - mv0 !== 1) begin
      errors++;
      $display("FAIL t2_pulse_count got %0d exp 1", mv_cnt - mv0);
    end
  endtask

  task automatic test_lock();
    int mv0;
    bus.thresh_lo = 32'd100;
    bus.thresh_hi = 32'd400;
    bus.f0_in = 8'h12;
    bus.f1_in = 8'hE5;
    mv0 = mv_cnt;
    repeat (4) send_window(8, -8, 1'b0);
    send_sample(0, 1'b0);
    checks++;
    if (bus.mse_valid !== 1'b1 || bus.converged !== 1'b0) begin
      errors++;
      $display("FAIL t3_pre_lock got mv=%0b conv=%0b exp mv=1 conv=0", bus.mse_valid, bus.converged);
    end
    send_sample(0, 1'b0);
    checks++;
    if (bus.converged !== 1'b1 || bus.f0_snap !== 8'h12 || bus.f1_snap !== 8'hE5) begin
      errors++;
      $display("FAIL t3_lock got conv=%0b f0=%h f1=%h exp conv=1 f0=12 f1=e5",
               bus.converged, bus.f0_snap, bus.f1_snap);
    end
    checks++;
    if (mv_cnt - mv0 !== 4 || last_mse !== 32'd64) begin
      errors++;
      $display("FAIL t3_back_to_back got windows=%0d mse=%0d exp windows=4 mse=64", mv_cnt - mv0, last_mse);
    end
  endtask

  task automatic test_broken_lock();
    clear = 1'b1;
    send_sample(0, 1'b0);
    clear = 1'b0;
    checks++;
    if (bus.converged !== 1'b0 || bus.f0_snap !== 8'h12) begin
      errors++;
      $display("FAIL t4_clear got conv=%0b f0=%h exp conv=0 f0=12", bus.converged, bus.f0_snap);
    end
    send_window(8, -8, 1'b0);
    send_window(8, -8, 1'b0);
    send_window(20, -20, 1'b0);
    repeat (3) send_window(8, -8, 1'b0);
    send_sample(0, 1'b0);
    send_sample(0, 1'b0);
    checks++;
    if (bus.converged !== 1'b0) begin
      errors++;
      $display("FAIL t4_three_fresh got conv=%0b exp 0", bus.converged);
    end
    send_window(8, -8, 1'b0);
    send_sample(0, 1'b0);
    send_sample(0, 1'b0);
    checks++;
    if (bus.converged !== 1'b1) begin
      errors++;
      $display("FAIL t4_four_fresh got conv=%0b exp 1", bus.converged);
    end
  endtask

  task automatic test_hold_and_loss();
    int lost0;
    lost0 = lost_cnt;
    bus.f0_in = 8'h33;
    bus.f1_in = 8'h44;
    send_window(16, -16, 1'b0);
    send_window(16, -16, 1'b0);
    send_sample(0, 1'b0);
    send_sample(0, 1'b0);
    checks++;
    if (bus.converged !== 1'b1 || bus.mse_out !== 32'd256) begin
      errors++;
      $display("FAIL t5_hold got conv=%0b mse=%0d exp conv=1 mse=256", bus.converged, bus.mse_out);
    end
    send_window(21, -21, 1'b0);
    send_sample(0, 1'b0);
    checks++;
    if (bus.mse_out !== 32'd441 || bus.converged !== 1'b1 || bus.lost !== 1'b0) begin
      errors++;
      $display("FAIL t5_eval got mse=%0d conv=%0b lost=%0b exp mse=441 conv=1 lost=0",
               bus.mse_out, bus.converged, bus.lost);
    end
    send_sample(0, 1'b0);
    checks++;
    if (bus.lost !== 1'b1 || bus.converged !== 1'b0) begin
      errors++;
      $display("FAIL t5_loss got lost=%0b conv=%0b exp lost=1 conv=0", bus.lost, bus.converged);
    end
    send_sample(0, 1'b0);
    checks++;
    if (bus.lost !== 1'b0 || lost_cnt - lost0 !== 1 || bus.f0_snap !== 8'h12 || bus.f1_snap !== 8'hE5) begin
      errors++;
      $display("FAIL t5_after got lost=%0b pulses=%0d f0=%h f1=%h exp lost=0 pulses=1 f0=12 f1=e5",
               bus.lost, lost_cnt - lost0, bus.f0_snap, bus.f1_snap);
    end
  endtask

  task automatic test_restart();
    int lost0;
    lost0 = lost_cnt;
    send_window(5, -5, 1'b0);
    send_window(5, -5, 1'b0);
    for (int i = 0; i < 10; i++) send_sample((i % 2 == 0) ? 100 : -100, 1'b1);
    clear = 1'b1;
    send_sample(100, 1'b1);
    clear = 1'b0;
    checks++;
    if (bus.mse_out !== 32'd25 || bus.mse_valid !== 1'b0) begin
      errors++;
      $display("FAIL t6_clear_hold got mse=%0d mv=%0b exp mse=25 mv=0", bus.mse_out, bus.mse_valid);
    end
    send_window(6, -6, 1'b0);
    send_sample(0, 1'b0);
    checks++;
    if (bus.mse_valid !== 1'b1 || bus.mse_out !== 32'd36) begin
      errors++;
      $display("FAIL t6_clear_window got mv=%0b mse=%0d exp mv=1 mse=36", bus.mse_valid, bus.mse_out);
    end
    bus.f0_in = 8'h55;
    bus.f1_in = 8'hAA;
    send_window(6, -6, 1'b0);
    send_window(6, -6, 1'b0);
    send_sample(0, 1'b0);
    send_sample(0, 1'b0);
    checks++;
    if (bus.converged !== 1'b0) begin
      errors++;
      $display("FAIL t6_clear_lockcnt got conv=%0b exp 0", bus.converged);
    end
    send_window(6, -6, 1'b0);
    send_sample(0, 1'b0);
    send_sample(0, 1'b0);
    bus.f0_in = 8'h66;
    clear = 1'b1;
    send_sample(0, 1'b0);
    clear = 1'b0;
    send_sample(0, 1'b0);
    checks++;
    if (bus.converged !== 1'b0 || bus.f0_snap !== 8'h55 || bus.f1_snap !== 8'hAA || lost_cnt != lost0) begin
      errors++;
      $display("FAIL t6_clear_conv got conv=%0b f0=%h f1=%h lost_pulses=%0d exp conv=0 f0=55 f1=aa lost_pulses=0",
               bus.converged, bus.f0_snap, bus.f1_snap, lost_cnt - lost0);
    end
    send_window(5, -5, 1'b0);
    for (int i = 0; i < 10; i++) send_sample((i % 2 == 0) ? 100 : -100, 1'b1);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.mse_out, bus.converged, bus.f0_snap, bus.f1_snap} !== '0) begin
      errors++;
      $display("FAIL t6_async_reset got mse=%0d conv=%0b f0=%h f1=%h exp all 0",
               bus.mse_out, bus.converged, bus.f0_snap, bus.f1_snap);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send_window(7, -7, 1'b0);
    send_sample(0, 1'b0);
    checks++;
    if (bus.mse_valid !== 1'b1 || bus.mse_out !== 32'd49) begin
      errors++;
      $display("FAIL t6_reset_window got mv=%0b mse=%0d exp mv=1 mse=49", bus.mse_valid, bus.mse_out);
    end
    send_window(7, -7, 1'b0);
    send_window(7, -7, 1'b0);
    send_sample(0, 1'b0);
    send_sample(0, 1'b0);
    checks++;
    if (bus.converged !== 1'b0 || lost_cnt != lost0) begin
      errors++;
      $display("FAIL t6_reset_lockcnt got conv=%0b lost_pulses=%0d exp conv=0 lost_pulses=0",
               bus.converged, lost_cnt - lost0);
    end
  endtask

  initial begin
    test_reset();
    test_basic_window();
    test_corner_and_gaps();
    test_lock();
    test_broken_lock();
    test_hold_and_loss();
    test_restart();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
